// File: rtl/readout_arbiter.sv
// readout_arbiter: round-robin merge of three readout sources into one downstream stream with flip-spin ack handling
module readout_arbiter #(
  parameter int ACK_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_local,
  input  logic [31:0] in_left,
  input  logic [31:0] in_right,
  output logic [2:0]  grant,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flip_ack,
  output logic [15:0] sent_cnt,
  output logic        err_timeout
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  state_t state, state_n;
  logic [1:0] ptr, sel;
  logic [7:0] ack_cnt;
  logic [2:0] req, rot;
  logic [2:0][31:0] words;
  logic [31:0] sel_word;
  logic [2:0] sum;
  logic ack_done, timeout;
  assign words = {in_right, in_left, in_local};
  assign req = {in_right[31:29] != 3'd5, in_left[31:29] != 3'd5, in_local[31:29] != 3'd5};
  // rot[k] is the request of port (ptr + k) mod 3, so the search starts at ptr
  assign rot = ptr == 2'd0 ? req : ptr == 2'd1 ? {req[0], req[2:1]} : {req[1:0], req[2]};
  assign sum = {1'b0, ptr} + (rot[0] ? 3'd0 : rot[1] ? 3'd1 : 3'd2);
  assign sel = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
  assign sel_word = words[sel];
  assign grant = (state == IDLE && |req) ? 3'b001 << sel : 3'b000;
  assign out_valid = state == SEND;
  assign timeout = ack_cnt == 8'(ACK_TIMEOUT - 1);
  assign ack_done = flip_ack || timeout;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (|req && sel_word[31:29] != 3'd0) ? SEND : IDLE;
      SEND:     state_n = out_ready ? (out_data[31:29] == 3'd6 ? WAIT_ACK : IDLE) : SEND;
      WAIT_ACK: state_n = ack_done ? IDLE : WAIT_ACK;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      out_data    <= 32'd0;
      sent_cnt    <= 16'd0;
      err_timeout <= 1'b0;
      ack_cnt     <= 8'd0;
    end else begin
      state   <= state_n;
      ack_cnt <= (state == WAIT_ACK && !ack_done) ? ack_cnt + 8'd1 : 8'd0;
      if (|grant) ptr <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
      if (|grant && sel_word[31:29] != 3'd0) out_data <= sel_word;
      if (state == SEND && out_ready) sent_cnt <= sent_cnt + 16'd1;
      if (state == WAIT_ACK && !flip_ack && timeout) err_timeout <= 1'b1;
    end
  end
endmodule
